// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_e  : FSM encoding (IDLE=00, BUSY=01, DONE=10)
//   REQ_CORE/DMA : requester IDs
//   TIMER_W      : width of the wait-state timer
//   dm_payload_t : one latched memory transfer
//   make_payload : builds the bus-ready payload (word address, read mask zeroed)
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } arb_state_e;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DMA  = 1'b1;

  localparam int TIMER_W = 8;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } dm_payload_t;

  // The memory bus only sees word addresses, and a read must never carry
  // byte enables, so both are normalised once at latch time.
  function automatic dm_payload_t make_payload(input logic        wr,
                                               input logic [31:0] addr,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  mask);
    dm_payload_t p;
    p.wr    = wr;
    p.addr  = {addr[31:2], 2'b00};
    p.wdata = wdata;
    p.mask  = wr ? mask : 4'b0000;
    return p;
  endfunction

endpackage

// File: rtl/dmem_arb_timer.sv
// Wait-state timer for the arbiter's BUSY state.
//   clk_in      : clock
//   rst_in      : asynchronous active-high reset (count -> 0)
//   clear_in    : synchronous clear, has priority over en_in
//   en_in       : increment by one
//   expired_out : count has reached TIMEOUT_CYCLES-1
module dmem_arb_timer
  import dmem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  input  logic en_in,
  output logic expired_out
);

  localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count <= '0;
    end else if (clear_in) begin
      count <= '0;
    end else if (en_in) begin
      count <= count + 1'b1;
    end
  end

  assign expired_out = (count == LAST_COUNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory bus arbiter between the core load/store path and a DMA/debug
// requester. A winner's payload is latched and held on the bus until the
// memory answers with dm_ready_in (or the wait-state timer expires), then the
// winner gets a one-cycle ack with its read data.
//
// Handshake: a requester raises *_req_in with a stable payload and keeps both
// unchanged until it sees its *_ack_out pulse; the ack is high for exactly one
// cycle (DONE) and the requester may drop or replace the request after it.
// The memory side sees dm_req_out high with a stable payload until it returns
// dm_ready_in for one cycle; dm_rdata_in is sampled with that pulse.
//
// Ports:
//   clk_in, rst_in                    : clock, asynchronous active-high reset
//   c_req_in/c_wr_in/c_addr_in/
//   c_wdata_in/c_mask_in              : core request and payload
//   c_rdata_out, c_ack_out            : core read data and completion pulse
//   c_stall_out                       : core request still outstanding
//   d_*                               : DMA equivalents (no stall output)
//   dm_req_out/dm_wr_out/dm_addr_out/
//   dm_wdata_out/dm_mask_out          : memory bus request (registered)
//   dm_rdata_in, dm_ready_in          : memory response
//   err_out                           : pulse with the ack of a timed-out transfer
//
// Build option: define DMEM_ARB_RR_EN for round-robin tie breaking; without it
// the core always wins a tie.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        c_req_in,
  input  logic        c_wr_in,
  input  logic [31:0] c_addr_in,
  input  logic [31:0] c_wdata_in,
  input  logic [3:0]  c_mask_in,
  output logic [31:0] c_rdata_out,
  output logic        c_ack_out,
  output logic        c_stall_out,
  input  logic        d_req_in,
  input  logic        d_wr_in,
  input  logic [31:0] d_addr_in,
  input  logic [31:0] d_wdata_in,
  input  logic [3:0]  d_mask_in,
  output logic [31:0] d_rdata_out,
  output logic        d_ack_out,
  output logic        dm_req_out,
  output logic        dm_wr_out,
  output logic [31:0] dm_addr_out,
  output logic [31:0] dm_wdata_out,
  output logic [3:0]  dm_mask_out,
  input  logic [31:0] dm_rdata_in,
  input  logic        dm_ready_in,
  output logic        err_out
);

  arb_state_e  state, state_next;
  dm_payload_t payload;
  dm_payload_t payload_next;
  logic        grant_id;
  logic        winner_next;
  logic        dm_wr;
  logic        err_flag;
  logic [31:0] c_rdata;
  logic [31:0] d_rdata;

  logic        load;
  logic        done_ok;
  logic        done_timeout;
  logic        timer_clear;
  logic        timer_en;
  logic        timer_expired;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef DMEM_ARB_RR_EN
  logic last_grant;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_grant <= REQ_DMA;  // so the core takes the first tie
    end else if (load) begin
      last_grant <= winner_next;
    end
  end

  always_comb begin
    if (c_req_in && d_req_in) begin
      winner_next = ~last_grant;
    end else if (c_req_in) begin
      winner_next = REQ_CORE;
    end else begin
      winner_next = REQ_DMA;
    end
  end
`else
  always_comb begin
    winner_next = c_req_in ? REQ_CORE : REQ_DMA;
  end
`endif

  always_comb begin
    if (winner_next == REQ_CORE) begin
      payload_next = make_payload(c_wr_in, c_addr_in, c_wdata_in, c_mask_in);
    end else begin
      payload_next = make_payload(d_wr_in, d_addr_in, d_wdata_in, d_mask_in);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    load         = 1'b0;
    done_ok      = 1'b0;
    done_timeout = 1'b0;
    timer_clear  = 1'b0;
    timer_en     = 1'b0;
    case (state)
      IDLE: begin
        if (c_req_in || d_req_in) begin
          load        = 1'b1;
          timer_clear = 1'b1;
          state_next  = BUSY;
        end
      end
      BUSY: begin
        // A response in the timeout cycle still counts as a success.
        if (dm_ready_in) begin
          done_ok    = 1'b1;
          state_next = DONE;
        end else if (timer_expired) begin
          done_timeout = 1'b1;
          state_next   = DONE;
        end else begin
          timer_en = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  dmem_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .clear_in   (timer_clear),
    .en_in      (timer_en),
    .expired_out(timer_expired)
  );

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      payload  <= '0;
      grant_id <= REQ_CORE;
      dm_wr    <= 1'b0;
      err_flag <= 1'b0;
      c_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      if (load) begin
        payload  <= payload_next;
        grant_id <= winner_next;
        dm_wr    <= payload_next.wr;
        err_flag <= 1'b0;
      end
      // Write enable only lives while the request is on the bus.
      if (done_ok || done_timeout) begin
        dm_wr <= 1'b0;
      end
      if (done_timeout) begin
        err_flag <= 1'b1;
      end
      // Reads return memory data; a timeout returns zero for reads and writes
      // alike so the requester never consumes stale data from an aborted
      // transfer. Successful writes leave rdata untouched.
      if (done_ok && !payload.wr) begin
        if (grant_id == REQ_CORE) begin
          c_rdata <= dm_rdata_in;
        end else begin
          d_rdata <= dm_rdata_in;
        end
      end else if (done_timeout) begin
        if (grant_id == REQ_CORE) begin
          c_rdata <= '0;
        end else begin
          d_rdata <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dm_req_out   = (state == BUSY);
  assign dm_wr_out    = dm_wr;
  assign dm_addr_out  = payload.addr;
  assign dm_wdata_out = payload.wdata;
  assign dm_mask_out  = payload.mask;

  assign c_ack_out    = (state == DONE) && (grant_id == REQ_CORE);
  assign d_ack_out    = (state == DONE) && (grant_id == REQ_DMA);
  assign err_out      = (state == DONE) && err_flag;
  assign c_stall_out  = c_req_in & ~c_ack_out;

  assign c_rdata_out  = c_rdata;
  assign d_rdata_out  = d_rdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory bus between the core's load/store path (store-unit outputs plus load requests) and a DMA/debug requester. Requests are sequenced through a small FSM that latches the winner's payload, holds it on the memory bus until the memory responds with `dm_ready_in`, then returns read data with a one-cycle ack. A wait-state timeout with an error flag stops a missing `dm_ready_in` from hanging the pipeline.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum BUSY cycles without `dm_ready_in` before abort; legal range 1..255.
- `clk_in` in 1: clock; all state changes on the rising edge.
- `rst_in` in 1: asynchronous, active-high reset.
- `c_req_in` in 1: core request; held with its payload until `c_ack_out`.
- `c_wr_in` in 1: core write (1) or read (0).
- `c_addr_in` in 32: core byte address.
- `c_wdata_in` in 32: core write data, already lane-aligned.
- `c_mask_in` in 4: core byte-write mask.
- `c_rdata_out` out 32: read data to core.
- `c_ack_out` out 1: one-cycle completion pulse to core.
- `c_stall_out` out 1: `c_req_in & ~c_ack_out`, combinational.
- `d_req_in`, `d_wr_in`, `d_addr_in`, `d_wdata_in`, `d_mask_in`: DMA equivalents of the core inputs, same widths.
- `d_rdata_out` out 32, `d_ack_out` out 1: DMA equivalents of the core outputs.
- `dm_req_out` out 1: memory request.
- `dm_wr_out` out 1: memory write enable.
- `dm_addr_out` out 32: word address, bits [1:0] forced to 0.
- `dm_wdata_out` out 32: memory write data.
- `dm_mask_out` out 4: latched mask on writes, 4'b0000 on reads.
- `dm_rdata_in` in 32: memory read data, valid with `dm_ready_in`.
- `dm_ready_in` in 1: memory completion.
- `err_out` out 1: one-cycle pulse, coincident with the ack, when a transfer times out.

## Operation
FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If any request is pending, pick a winner, register its payload and ID, clear the timer, go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - `dm_req_out`=1; all `dm_*` outputs come from registers and stay stable.
  - If `dm_ready_in`=1: capture `dm_rdata_in` into the winner's rdata register (reads only), go to DONE.
  - Else if timer = `TIMEOUT_CYCLES`-1: set the error flag, go to DONE; the winner's rdata register is set to 0.
  - Else: increment the timer.
- **DONE**
  - Winner's ack = 1 for exactly this cycle; `err_out` = error flag.
  - Next state is always IDLE.
  - DONE exists so the requester can drop its request before the next arbitration.
- **Writes:** the rdata register is unchanged.
- **Non-winner outputs:** the non-winner's rdata holds its previous value; its ack stays 0.
- **Requester rule:** `*_req_in` and payload stay stable until the matching ack. A request dropped early is undefined.
- **Arbitration:** default is fixed priority, core over DMA (see Configuration).

## Timing
- Reset values (asynchronous, immediate):
  - State = IDLE.
  - All acks, `dm_req_out`, `dm_wr_out` and `err_out` = 0.
  - `dm_addr_out`, `dm_wdata_out` and both rdata outputs = 0; `dm_mask_out` = 0.
  - Timer = 0; last-grant = DMA.
- Latency with zero-wait memory (`dm_ready_in`=1 in the first BUSY cycle): request seen at edge 0, `dm_req_out` high from edge 0 to edge 1, ack high from edge 1 to edge 2. Request-to-ack is 2 cycles.
- Each cycle `dm_ready_in` is low adds one cycle.
- Back-to-back: after DONE, IDLE samples requests again, so throughput is at most one transfer per 3 cycles.
- A `dm_ready_in` arriving in the same cycle as the timeout wins: no error.
- `dm_ready_in` outside BUSY is ignored.
- Reset mid-transfer drops `dm_req_out` immediately; no ack is produced.

## Configuration
- `DMEM_ARB_RR_EN` defined:
  - A last-grant register is updated on every IDLE-to-BUSY transition.
  - When both requesters are active in IDLE, the one not granted last wins.
  - After reset, the core wins the first tie.
- Undefined:
  - Strict core priority; no last-grant register is built.
  - The DMA can starve under continuous core traffic (accepted).

## Structure
- Package `dmem_arb_pkg` holds:
  - State encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
  - Requester IDs: REQ_CORE=1'b0, REQ_DMA=1'b1.
  - Timer width constant: 8.
- Sub-module `dmem_arb_timer`: clear/enable counter with an `expired_out` compare against `TIMEOUT_CYCLES`-1. Instantiated once.

## Test plan
- Core read 0x0000_1006, memory returns 0xDEADBEEF with 0 wait states:
  - `dm_addr_out`=0x0000_1004, `dm_mask_out`=0.
  - `c_rdata_out`=0xDEADBEEF, `c_ack_out` 2 cycles after the request.
- Core write, mask 4'b0100, data 0x00AB_0000, 3 wait states:
  - `dm_wr_out`=1 with payload stable for 4 BUSY cycles.
  - `c_ack_out` at cycle 5; `c_stall_out` high until the ack.
- Core and DMA request in the same cycle:
  - Core is served first, then DMA.
  - With `DMEM_ARB_RR_EN` and continuous requests from both, grants alternate C, D, C, D; without it, the DMA never wins.
- `TIMEOUT_CYCLES`=4, `dm_ready_in` held at 0:
  - `dm_req_out` high exactly 4 cycles.
  - `d_ack_out` and `err_out` pulse together; `d_rdata_out`=0.
- `rst_in` asserted during BUSY:
  - `dm_req_out`=0 immediately; no ack.
  - After release, a new request completes normally.
